// File: rtl/mips16_pkg.sv
// mips16_pkg: shared arbiter state and owner encodings for the mips16 memory path
package mips16_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} arb_owner_t;
endpackage

// File: rtl/mips16_arb_pick.sv
// mips16_arb_pick: data-first winner selection with a streak limit that guarantees fetch progress
module mips16_arb_pick
  import mips16_pkg::*;
#(
  parameter int DM_STREAK_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       if_req_i,
  input  logic       dm_req_i,
  input  logic       idle_i,
  input  logic       grant_i,
  output arb_owner_t winner_o
);
  localparam int SW = $clog2(DM_STREAK_MAX + 1);
  logic [SW-1:0] streak_q, streak_d;
  logic          at_max;
  assign at_max   = streak_q == SW'(DM_STREAK_MAX);
  assign winner_o = (dm_req_i && !(if_req_i && at_max)) ? OWN_DM : if_req_i ? OWN_IF : OWN_NONE;
  // a DM grant with no fetch waiting is also an idle cycle without if_req, so it clears
  always_comb begin
    streak_d = streak_q;
    if ((grant_i && winner_o == OWN_IF) || (idle_i && !if_req_i))
      streak_d = '0;
    else if (grant_i && winner_o == OWN_DM && !at_max)
      streak_d = streak_q + SW'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
endmodule

// File: rtl/mips16_mem_arbiter.sv
// mips16_mem_arbiter: shares one fixed-latency single-port memory between fetch (IF) and load/store (DM)
module mips16_mem_arbiter
  import mips16_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int MEM_LATENCY   = 1,
  parameter int DM_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d, winner;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d, idle, grant;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  assign idle  = state_q == ARB_IDLE;
  assign grant = idle && winner != OWN_NONE;
  mips16_arb_pick #(.DM_STREAK_MAX(DM_STREAK_MAX)) u_pick (
    .clk      (clk),
    .reset    (reset),
    .if_req_i (if_req),
    .dm_req_i (dm_req),
    .idle_i   (idle),
    .grant_i  (grant),
    .winner_o (winner)
  );
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      ARB_IDLE: if (grant) begin
        state_d = ARB_ISSUE;
        owner_d = winner;
        addr_d  = winner == OWN_DM ? dm_addr : if_addr;
        we_d    = winner == OWN_DM && dm_we;
        wdata_d = winner == OWN_DM ? dm_wdata : wdata_q;
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
        cnt_d   = CW'(MEM_LATENCY);
      end
      ARB_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        // last wait cycle is the one in which mem_rdata is valid
        if (cnt_q == CW'(1)) begin
          state_d    = ARB_RESP;
          if_rdata_d = owner_q == OWN_IF ? mem_rdata : if_rdata_q;
          dm_rdata_d = (owner_q == OWN_DM && !we_q) ? mem_rdata : dm_rdata_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_NONE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  assign mem_en    = state_q == ARB_ISSUE;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ready  = state_q == ARB_RESP && owner_q == OWN_IF;
  assign dm_ready  = state_q == ARB_RESP && owner_q == OWN_DM;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = !idle;
endmodule

// File: tb/tb_mips16_mem_arbiter.sv
// tb_mips16_mem_arbiter: directed checks of arbitration, timing, streak limit and reset for L=1 and L=3
module tb_mips16_mem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic        if_req = 0, if_ready, dm_req = 0, dm_we = 0, dm_ready, mem_en, mem_we, busy;
  logic [15:0] if_addr = 0, if_rdata, dm_addr = 0, dm_wdata = 0, dm_rdata, mem_addr, mem_wdata, rd_a;
  logic        b_if_req = 0, b_if_ready, b_dm_ready, b_mem_en, b_mem_we, b_busy;
  logic [15:0] b_if_addr = 0, b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_p1, b_p2, b_p3;
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  int checks = 0, errors = 0;
  mips16_mem_arbiter #(.MEM_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rd_a), .busy(busy)
  );
  mips16_mem_arbiter #(.MEM_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready),
    .if_rdata(b_if_rdata), .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0), .dm_wdata(16'h0),
    .dm_ready(b_dm_ready), .dm_rdata(b_dm_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_p3), .busy(b_busy)
  );
  // memory models: data is only defined in the cycle the arbiter is allowed to sample it
  always @(posedge clk) begin
    rd_a <= mem_en ? mem_a[mem_addr[7:0]] : 16'hxxxx;
    if (mem_en && mem_we) mem_a[mem_addr[7:0]] <= mem_wdata;
    b_p1 <= b_mem_en ? mem_b[b_mem_addr[7:0]] : 16'hxxxx;
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [9:0] pat;
    int g;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] <= 16'h5A00 ^ 16'(i);
      mem_b[i] <= 16'h5A00 ^ 16'(i);
    end
    #0;
    mem_a[8'h10] <= 16'hABCD;
    mem_a[8'h30] <= 16'h1357;
    mem_b[8'h10] <= 16'hABCD;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_outs", {if_ready, dm_ready, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata}, 0);
    step();
    reset = 0;
    // single fetch, L=1
    if_req = 1; if_addr = 16'h0010;
    step();
    chk("t1_mem_en_c1", mem_en, 1);
    chk("t1_mem_addr_c1", mem_addr, 16'h0010);
    chk("t1_mem_we_c1", mem_we, 0);
    chk("t1_busy_c1", busy, 1);
    step();
    chk("t1_c2", {mem_en, if_ready, busy}, 3'b001);
    step();
    chk("t1_if_ready_c3", if_ready, 1);
    chk("t1_if_rdata_c3", if_rdata, 16'hABCD);
    chk("t1_dm_ready_c3", dm_ready, 0);
    if_req = 0;
    step();
    chk("t1_idle_c4", {if_ready, busy}, 2'b00);
    // store
    dm_req = 1; dm_we = 1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    step();
    chk("t2_mem_en_we_c1", {mem_en, mem_we}, 2'b11);
    chk("t2_mem_wdata_c1", mem_wdata, 16'h1234);
    chk("t2_mem_addr_c1", mem_addr, 16'h0020);
    step();
    chk("t2_no_ready_c2", dm_ready, 0);
    step();
    chk("t2_dm_ready_c3", dm_ready, 1);
    chk("t2_if_ready_c3", if_ready, 0);
    chk("t2_rdata_kept", {if_rdata, dm_rdata}, {16'hABCD, 16'h0000});
    dm_req = 0; dm_we = 0;
    step();
    chk("t2_mem_we_idle", {mem_en, mem_we, busy}, 3'b000);
    // load back the stored word
    dm_req = 1; dm_addr = 16'h0020;
    step(); step(); step();
    chk("t2b_dm_ready", dm_ready, 1);
    chk("t2b_dm_rdata", dm_rdata, 16'h1234);
    dm_req = 0;
    step();
    // simultaneous requests: DM first
    if_req = 1; if_addr = 16'h0040; dm_req = 1; dm_addr = 16'h0030;
    step();
    chk("t3_dm_first_addr", mem_addr, 16'h0030);
    step(); step();
    chk("t3_dm_ready_c3", {dm_ready, if_ready}, 2'b10);
    chk("t3_dm_rdata_c3", dm_rdata, 16'h1357);
    dm_req = 0;
    step();
    chk("t3_idle_c4", busy, 0);
    step();
    chk("t3_if_issue_c5", {mem_en, mem_addr}, {1'b1, 16'h0040});
    step(); step();
    chk("t3_if_ready_c7", {if_ready, dm_ready}, 2'b10);
    chk("t3_if_rdata_c7", if_rdata, 16'h5A40);
    chk("t3_dm_rdata_kept", dm_rdata, 16'h1357);
    if_req = 0;
    step();
    // both held: four DM grants then one IF grant, repeating
    if_req = 1; if_addr = 16'h0050; dm_req = 1; dm_addr = 16'h0060;
    pat = '0; g = 0;
    for (int c = 0; c < 60 && g < 10; c++) begin
      step();
      if (mem_en) begin
        pat[g] = mem_addr == 16'h0060;
        g++;
      end
    end
    chk("t4_grant_count", g, 10);
    chk("t4_grant_pattern", pat, 10'b0111101111);
    if_req = 0; dm_req = 0;
    for (int c = 0; c < 10 && busy; c++) step();
    chk("t4_drain", busy, 0);
    // reset in the wait cycle of a DM load
    dm_req = 1; dm_addr = 16'h0030;
    step();
    chk("t5_issue", mem_en, 1);
    step();
    chk("t5_wait_busy", {busy, mem_en}, 2'b10);
    reset = 1;
    #1;
    chk("t5_rst_now", {busy, dm_ready, if_ready, mem_en, mem_we, mem_addr, mem_wdata}, 0);
    chk("t5_rst_rdata", {if_rdata, dm_rdata}, 0);
    step();
    chk("t5_no_ready", {dm_ready, busy}, 2'b00);
    reset = 0;
    step();
    chk("t5_reissue", {mem_en, mem_addr}, {1'b1, 16'h0030});
    step(); step();
    chk("t5_dm_ready", dm_ready, 1);
    chk("t5_dm_rdata", dm_rdata, 16'h1357);
    dm_req = 0;
    step();
    // L=3 fetch
    b_if_req = 1; b_if_addr = 16'h0010;
    step();
    chk("t6_mem_en_c1", {b_mem_en, b_mem_addr}, {1'b1, 16'h0010});
    step(); step(); step();
    chk("t6_c4_not_ready", {b_if_ready, b_busy, b_mem_en}, 3'b010);
    chk("t6_c4_rdata_old", b_if_rdata, 16'h0000);
    step();
    chk("t6_if_ready_c5", b_if_ready, 1);
    chk("t6_if_rdata_c5", b_if_rdata, 16'hABCD);
    chk("t6_dm_ready_c5", b_dm_ready, 0);
    step();
    chk("t6_idle_c6", {b_mem_en, b_busy, b_if_ready}, 3'b000);
    step();
    chk("t6_reissue_c7", b_mem_en, 1);
    b_if_req = 0;
    for (int c = 0; c < 10 && b_busy; c++) step();
    chk("t6_drain", b_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
